// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Cleans up the raw push-buttons and turns them into the one-hot command word
// that the calculator FSM decodes. Bit 0 is clear/reset. Bits 1..4 are add,
// multiply, divide and modulo.
//
// Each button goes through three stages:
//   1. A 2-flop synchronizer.
//   2. A counter debounce. The synced level must differ from the accepted
//      level for DEBOUNCE_CYCLES consecutive cycles before it is taken.
//   3. Rising-edge detection on the accepted level.
//
// Accepted presses collect in a pending buffer. The buffer is drained one
// button per cycle, lowest index first. This keeps `buttons` all-zero or
// exactly one-hot, so simultaneous presses become consecutive pulses.
//
// Ports:
//   clk       : system clock (100 MHz)
//   rst_n     : asynchronous active-low reset
//   btn_raw   : raw asynchronous button levels, 1 = pressed
//   buttons   : one-hot press pulse, high for exactly one cycle per press
//   btn_level : debounced stable level of each button
//   pending   : presses accepted but not yet emitted
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] buttons,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] pending
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [N_BTN-1:0] BTN_ONE  = N_BTN'(1);

  logic [N_BTN-1:0] sync1_q, sync1_d;
  logic [N_BTN-1:0] sync2_q, sync2_d;
  logic [N_BTN-1:0] stable_q, stable_d;
  logic [N_BTN-1:0] pending_q, pending_d;
  logic [N_BTN-1:0] buttons_q, buttons_d;
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];
  logic [N_BTN-1:0] rise_s;
  logic [N_BTN-1:0] grant_s;

  // Next-state logic: synchronizer, debounce counters, press detect and emit.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;

    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i]    = cnt_q[i];
      stable_d[i] = stable_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        // Any return to the accepted level restarts the qualification window.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end

    // Only accepted 0->1 transitions count as presses. Releases are silent.
    rise_s = stable_d & ~stable_q;

    // Two's-complement trick isolates the lowest set bit (highest priority).
    grant_s = pending_q & (~pending_q + BTN_ONE);

    // OR-ing the new presses in after the clear makes a set win over a
    // same-cycle clear, so a press is never dropped.
    pending_d = (pending_q & ~grant_s) | rise_s;
    buttons_d = grant_s;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      pending_q <= '0;
      buttons_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      pending_q <= pending_d;
      buttons_q <= buttons_d;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign buttons   = buttons_q;
  assign btn_level = stable_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Self-checking bench for button_conditioner. Uses two instances:
//   u_dut      : DEBOUNCE_CYCLES = 4, for the short scenarios.
//   u_dut_long : DEBOUNCE_CYCLES = 5000, for the long-hold scenario. This
//                keeps the run short but still exercises a wide counter.
//
// Each scenario pushes the pulses it expects onto a scoreboard queue, then
// steps edge by edge. Raw inputs are driven before each rising edge. Outputs
// are sampled on the following falling edge.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int N_BTN = 5;

  typedef struct {
    int               edge_no;
    logic [N_BTN-1:0] val;
  } sb_t;

  logic             clk;
  logic             rst_n;
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] buttons;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] pending;
  logic [N_BTN-1:0] btn_raw_l;
  logic [N_BTN-1:0] buttons_l;
  logic [N_BTN-1:0] btn_level_l;
  logic [N_BTN-1:0] pending_l;

  sb_t sb[$];
  int  n_checks;
  int  n_fail;

  button_conditioner #(
    .N_BTN          (N_BTN),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_raw),
    .buttons  (buttons),
    .btn_level(btn_level),
    .pending  (pending)
  );

  button_conditioner #(
    .N_BTN          (N_BTN),
    .DEBOUNCE_CYCLES(5000),
    .CNT_W          (13)
  ) u_dut_long (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_raw_l),
    .buttons  (buttons_l),
    .btn_level(btn_level_l),
    .pending  (pending_l)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset;
    rst_n     = 1'b0;
    btn_raw   = 5'b00000;
    btn_raw_l = 5'b00000;
    repeat (3) @(negedge clk);
    n_checks++;
    if (buttons !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_buttons: got %b expected 00000", buttons);
    end
    n_checks++;
    if (btn_level !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_btn_level: got %b expected 00000", btn_level);
    end
    n_checks++;
    if (pending !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_pending: got %b expected 00000", pending);
    end
    n_checks++;
    if ({buttons_l, btn_level_l, pending_l} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_long: got %b expected all zero", {buttons_l, btn_level_l, pending_l});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_clean_press;
    logic [N_BTN-1:0] exp;
    logic             exp_lvl;
    sb.push_back('{7, 5'b00010});
    for (int e = 1; e <= 40; e++) begin
      btn_raw = (e <= 30) ? 5'b00010 : 5'b00000;
      @(posedge clk);
      @(negedge clk);
      exp = 5'b00000;
      if (sb.size() > 0 && sb[0].edge_no == e) begin
        exp = sb[0].val;
        void'(sb.pop_front());
      end
      n_checks++;
      if (buttons !== exp) begin
        n_fail++;
        $display("FAIL clean_press_buttons edge %0d: got %b expected %b", e, buttons, exp);
      end
      if (e <= 30) begin
        exp_lvl = (e >= 6) ? 1'b1 : 1'b0;
        n_checks++;
        if (btn_level[1] !== exp_lvl) begin
          n_fail++;
          $display("FAIL clean_press_level edge %0d: got %b expected %b", e, btn_level[1], exp_lvl);
        end
      end
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL clean_press_missing: %0d pulses outstanding, expected 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_bounce;
    logic [N_BTN-1:0] exp;
    logic             b;
    // The final press edge is sampled at edge 5, so the pulse lands after edge 11.
    sb.push_back('{11, 5'b00100});
    for (int e = 1; e <= 40; e++) begin
      if (e <= 4)       b = (e % 2 == 1) ? 1'b1 : 1'b0;
      else if (e <= 20) b = 1'b1;
      else if (e <= 24) b = (e % 2 == 0) ? 1'b1 : 1'b0;
      else              b = 1'b0;
      btn_raw = {2'b00, b, 2'b00};
      @(posedge clk);
      @(negedge clk);
      exp = 5'b00000;
      if (sb.size() > 0 && sb[0].edge_no == e) begin
        exp = sb[0].val;
        void'(sb.pop_front());
      end
      n_checks++;
      if (buttons !== exp) begin
        n_fail++;
        $display("FAIL bounce_buttons edge %0d: got %b expected %b", e, buttons, exp);
      end
    end
    n_checks++;
    if (btn_level !== 5'b00000) begin
      n_fail++;
      $display("FAIL bounce_release_level: got %b expected 00000", btn_level);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL bounce_missing: %0d pulses outstanding, expected 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_simultaneous;
    logic [N_BTN-1:0] exp;
    logic [N_BTN-1:0] exp_pend;
    sb.push_back('{7, 5'b00010});
    sb.push_back('{8, 5'b01000});
    sb.push_back('{9, 5'b10000});
    for (int e = 1; e <= 32; e++) begin
      btn_raw = (e <= 20) ? 5'b11010 : 5'b00000;
      @(posedge clk);
      @(negedge clk);
      exp = 5'b00000;
      if (sb.size() > 0 && sb[0].edge_no == e) begin
        exp = sb[0].val;
        void'(sb.pop_front());
      end
      case (e)
        6:       exp_pend = 5'b11010;
        7:       exp_pend = 5'b11000;
        8:       exp_pend = 5'b10000;
        default: exp_pend = 5'b00000;
      endcase
      n_checks++;
      if (buttons !== exp) begin
        n_fail++;
        $display("FAIL simultaneous_buttons edge %0d: got %b expected %b", e, buttons, exp);
      end
      n_checks++;
      if (pending !== exp_pend) begin
        n_fail++;
        $display("FAIL simultaneous_pending edge %0d: got %b expected %b", e, pending, exp_pend);
      end
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL simultaneous_missing: %0d pulses outstanding, expected 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_repress;
    logic [N_BTN-1:0] exp;
    logic             b;
    // Phases of the bit-0 input:
    //   press 1-15, release 16-25 (long), press 26-45, release 46-55,
    //   press 56-70, release 71-73 (too short to register), press 74-90,
    //   release from 91.
    sb.push_back('{7,  5'b00001});
    sb.push_back('{32, 5'b00001});
    sb.push_back('{62, 5'b00001});
    for (int e = 1; e <= 105; e++) begin
      b = ((e <= 15) || (e >= 26 && e <= 45) || (e >= 56 && e <= 70) ||
           (e >= 74 && e <= 90)) ? 1'b1 : 1'b0;
      btn_raw = {4'b0000, b};
      @(posedge clk);
      @(negedge clk);
      exp = 5'b00000;
      if (sb.size() > 0 && sb[0].edge_no == e) begin
        exp = sb[0].val;
        void'(sb.pop_front());
      end
      n_checks++;
      if (buttons !== exp) begin
        n_fail++;
        $display("FAIL repress_buttons edge %0d: got %b expected %b", e, buttons, exp);
      end
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL repress_missing: %0d pulses outstanding, expected 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset_midflight;
    logic [N_BTN-1:0] exp;
    btn_raw = 5'b01000;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({buttons, btn_level, pending} !== 15'd0) begin
      n_fail++;
      $display("FAIL midflight_reset_outputs: got %b expected all zero", {buttons, btn_level, pending});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // The button is still held, so it is a fresh press counted from deassertion.
    sb.push_back('{7, 5'b01000});
    for (int e = 1; e <= 25; e++) begin
      btn_raw = (e <= 15) ? 5'b01000 : 5'b00000;
      @(posedge clk);
      @(negedge clk);
      exp = 5'b00000;
      if (sb.size() > 0 && sb[0].edge_no == e) begin
        exp = sb[0].val;
        void'(sb.pop_front());
      end
      n_checks++;
      if (buttons !== exp) begin
        n_fail++;
        $display("FAIL midflight_buttons edge %0d: got %b expected %b", e, buttons, exp);
      end
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL midflight_missing: %0d pulses outstanding, expected 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_long_hold;
    logic [N_BTN-1:0] exp;
    logic             exp_lvl;
    // DEBOUNCE_CYCLES = 5000, so the pulse lands after edge 5003.
    sb.push_back('{5003, 5'b10000});
    for (int e = 1; e <= 15000; e++) begin
      btn_raw_l = 5'b10000;
      @(posedge clk);
      @(negedge clk);
      exp = 5'b00000;
      if (sb.size() > 0 && sb[0].edge_no == e) begin
        exp = sb[0].val;
        void'(sb.pop_front());
      end
      exp_lvl = (e >= 5002) ? 1'b1 : 1'b0;
      n_checks++;
      if (buttons_l !== exp) begin
        n_fail++;
        $display("FAIL long_hold_buttons edge %0d: got %b expected %b", e, buttons_l, exp);
      end
      n_checks++;
      if (btn_level_l[4] !== exp_lvl) begin
        n_fail++;
        $display("FAIL long_hold_level edge %0d: got %b expected %b", e, btn_level_l[4], exp_lvl);
      end
    end
    btn_raw_l = 5'b00000;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL long_hold_missing: %0d pulses outstanding, expected 0", sb.size());
    end
    sb.delete();
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    btn_raw   = 5'b00000;
    btn_raw_l = 5'b00000;
    test_reset();
    @(negedge clk);
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_repress();
    test_reset_midflight();
    test_long_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
